// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_unit
//  Description : Circular reorder buffer with in-order, two-wide retire.
//                Dispatch allocates up to 2 rows per cycle, functional units
//                complete up to 3 rows per cycle, and retire drives register
//                writes, store commits and physical-register frees.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_unit #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_alloc_valid     [0:1],
    input  logic              i_alloc_reg_write [0:1],
    input  logic              i_alloc_mem_write [0:1],
    input  logic [PREG_W-1:0] i_alloc_pdst      [0:1],
    input  logic [PREG_W-1:0] i_alloc_old_pdst  [0:1],
    output logic              o_alloc_ready,
    output logic [IDX_W-1:0]  o_alloc_idx       [0:1],
    input  logic              i_cmpl_valid      [0:2],
    input  logic [IDX_W-1:0]  i_cmpl_idx        [0:2],
    input  logic [XLEN-1:0]   i_cmpl_data       [0:2],
    output logic              o_w_reg_en        [0:1],
    output logic [PREG_W-1:0] o_w_reg_addr      [0:1],
    output logic [XLEN-1:0]   o_w_reg_data      [0:1],
    output logic              o_w_mem_en        [0:1],
    output logic [XLEN-1:0]   o_w_mem_addr      [0:1],
    output logic [PREG_W-1:0] o_st_preg         [0:1],
    output logic              o_free_en         [0:1],
    output logic [PREG_W-1:0] o_free_preg       [0:1],
    output logic [IDX_W:0]    o_count,
    output logic              o_empty,
    output logic              o_full
);

    localparam logic [IDX_W:0] C_DEPTH = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] C_TWO   = (IDX_W+1)'(2);

    // Pointers, occupancy and per-row state
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              empty_q, full_q;
    logic [DEPTH-1:0]  valid_q, done_q, rw_q, mw_q;
    logic [PREG_W-1:0] pdst_q [DEPTH];
    logic [PREG_W-1:0] old_q  [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];

    logic [IDX_W-1:0]  w_head1, w_tail1;
    logic              w_ready, w_acc0, w_acc1, w_ret0, w_ret1;
    logic [1:0]        w_n_alloc, w_n_ret;

    // Allocation acceptance, retire selection and next pointer/count values
    always_comb begin
        w_head1   = head_q + IDX_W'(1);
        w_tail1   = tail_q + IDX_W'(1);
        // Only the registered count gates allocation; same-cycle retires are not credited
        w_ready   = (C_DEPTH - count_q) >= C_TWO;
        w_acc0    = w_ready & i_alloc_valid[0];
        // Lane 1 alone is illegal and ignored
        w_acc1    = w_acc0 & i_alloc_valid[1];
        w_ret0    = valid_q[head_q] & done_q[head_q];
        w_ret1    = w_ret0 & valid_q[w_head1] & done_q[w_head1];
        w_n_alloc = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_n_ret   = {1'b0, w_ret0} + {1'b0, w_ret1};
        head_d    = head_q + IDX_W'(w_n_ret);
        tail_d    = tail_q + IDX_W'(w_n_alloc);
        count_d   = count_q + {{(IDX_W-1){1'b0}}, w_n_alloc}
                            - {{(IDX_W-1){1'b0}}, w_n_ret};
    end

    // Tags offered to dispatch are simply the next two tail slots
    always_comb begin
        o_alloc_idx[0] = tail_q;
        o_alloc_idx[1] = w_tail1;
        o_alloc_ready  = w_ready;
        o_count        = count_q;
        o_empty        = empty_q;
        o_full         = full_q;
    end

    // ROB row storage: completions, then retire invalidation, then allocation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= '0;
            done_q  <= '0;
            rw_q    <= '0;
            mw_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pdst_q[i] <= '0;
                old_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            // Later lanes overwrite earlier ones when they target the same tag
            for (int l = 0; l < 3; l++) begin
                if (i_cmpl_valid[l] && valid_q[i_cmpl_idx[l]]) begin
                    done_q[i_cmpl_idx[l]] <= 1'b1;
                    data_q[i_cmpl_idx[l]] <= i_cmpl_data[l];
                end
            end
            if (w_ret0) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (w_ret1) begin
                valid_q[w_head1] <= 1'b0;
                done_q[w_head1]  <= 1'b0;
            end
            // Allocation targets are guaranteed free, so they never collide with retiring rows
            if (w_acc0) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                rw_q[tail_q]    <= i_alloc_reg_write[0];
                mw_q[tail_q]    <= i_alloc_mem_write[0];
                pdst_q[tail_q]  <= i_alloc_pdst[0];
                old_q[tail_q]   <= i_alloc_old_pdst[0];
            end
            if (w_acc1) begin
                valid_q[w_tail1] <= 1'b1;
                done_q[w_tail1]  <= 1'b0;
                rw_q[w_tail1]    <= i_alloc_reg_write[1];
                mw_q[w_tail1]    <= i_alloc_mem_write[1];
                pdst_q[w_tail1]  <= i_alloc_pdst[1];
                old_q[w_tail1]   <= i_alloc_old_pdst[1];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == C_DEPTH);
        end
    end

    // Registered retire outputs: one-cycle pulses for each slot that retires
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < 2; s++) begin
                o_w_reg_en[s]   <= 1'b0;
                o_w_reg_addr[s] <= '0;
                o_w_reg_data[s] <= '0;
                o_w_mem_en[s]   <= 1'b0;
                o_w_mem_addr[s] <= '0;
                o_st_preg[s]    <= '0;
                o_free_en[s]    <= 1'b0;
                o_free_preg[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                logic [IDX_W-1:0] e;
                logic             r;
                e = (s == 0) ? head_q : w_head1;
                r = ((s == 0) ? w_ret0 : w_ret1) & ~i_flush;
                // A store uses pdst as its data source, so it never writes the register file
                o_w_reg_en[s]   <= r & rw_q[e] & ~mw_q[e];
                o_w_reg_addr[s] <= (r & rw_q[e] & ~mw_q[e]) ? pdst_q[e] : '0;
                o_w_reg_data[s] <= (r & rw_q[e] & ~mw_q[e]) ? data_q[e] : '0;
                o_w_mem_en[s]   <= r & mw_q[e];
                o_w_mem_addr[s] <= (r & mw_q[e]) ? data_q[e] : '0;
                o_st_preg[s]    <= (r & mw_q[e]) ? pdst_q[e] : '0;
                o_free_en[s]    <= r & rw_q[e];
                o_free_preg[s]  <= (r & rw_q[e]) ? old_q[e] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit_unit
//  Description : Directed, self-checking bench for rob_commit_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_alloc_valid     [0:1];
    logic        i_alloc_reg_write [0:1];
    logic        i_alloc_mem_write [0:1];
    logic [5:0]  i_alloc_pdst      [0:1];
    logic [5:0]  i_alloc_old_pdst  [0:1];
    logic        o_alloc_ready;
    logic [3:0]  o_alloc_idx       [0:1];
    logic        i_cmpl_valid      [0:2];
    logic [3:0]  i_cmpl_idx        [0:2];
    logic [31:0] i_cmpl_data       [0:2];
    logic        o_w_reg_en        [0:1];
    logic [5:0]  o_w_reg_addr      [0:1];
    logic [31:0] o_w_reg_data      [0:1];
    logic        o_w_mem_en        [0:1];
    logic [31:0] o_w_mem_addr      [0:1];
    logic [5:0]  o_st_preg         [0:1];
    logic        o_free_en         [0:1];
    logic [5:0]  o_free_preg       [0:1];
    logic [4:0]  o_count;
    logic        o_empty;
    logic        o_full;

    int checks   = 0;
    int failures = 0;

    rob_commit_unit #(.DEPTH(16), .IDX_W(4), .PREG_W(6), .XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_alloc_valid(i_alloc_valid), .i_alloc_reg_write(i_alloc_reg_write),
        .i_alloc_mem_write(i_alloc_mem_write), .i_alloc_pdst(i_alloc_pdst),
        .i_alloc_old_pdst(i_alloc_old_pdst), .o_alloc_ready(o_alloc_ready),
        .o_alloc_idx(o_alloc_idx), .i_cmpl_valid(i_cmpl_valid),
        .i_cmpl_idx(i_cmpl_idx), .i_cmpl_data(i_cmpl_data),
        .o_w_reg_en(o_w_reg_en), .o_w_reg_addr(o_w_reg_addr),
        .o_w_reg_data(o_w_reg_data), .o_w_mem_en(o_w_mem_en),
        .o_w_mem_addr(o_w_mem_addr), .o_st_preg(o_st_preg),
        .o_free_en(o_free_en), .o_free_preg(o_free_preg),
        .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
    );

    always #5 i_clk = ~i_clk;

    // Packs all six retire enables: {reg0, reg1, mem0, mem1, free0, free1}
    function automatic logic [5:0] en_bits();
        return {o_w_reg_en[0], o_w_reg_en[1], o_w_mem_en[0], o_w_mem_en[1],
                o_free_en[0], o_free_en[1]};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_alloc_valid[k] = 1'b0; i_alloc_reg_write[k] = 1'b0;
            i_alloc_mem_write[k] = 1'b0; i_alloc_pdst[k] = '0; i_alloc_old_pdst[k] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            i_cmpl_valid[k] = 1'b0; i_cmpl_idx[k] = '0; i_cmpl_data[k] = '0;
        end
    endtask

    task automatic alloc(input int k, input logic rw, input logic mw,
                         input logic [5:0] pdst, input logic [5:0] old);
        i_alloc_valid[k] = 1'b1; i_alloc_reg_write[k] = rw; i_alloc_mem_write[k] = mw;
        i_alloc_pdst[k] = pdst; i_alloc_old_pdst[k] = old;
    endtask

    task automatic cmpl(input int k, input logic [3:0] idx, input logic [31:0] data);
        i_cmpl_valid[k] = 1'b1; i_cmpl_idx[k] = idx; i_cmpl_data[k] = data;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle();
        repeat (2) tick();
        checks++;
        if ({o_count, o_empty, o_full, o_alloc_ready} !== {5'd0, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL reset_status: got %b want %b",
                {o_count, o_empty, o_full, o_alloc_ready}, {5'd0, 3'b101});
        end
        checks++;
        if (en_bits() !== 6'b0 || o_w_reg_data[0] !== 32'd0 || o_w_mem_addr[0] !== 32'd0) begin
            failures++; $display("FAIL reset_outputs: enables %b data %h addr %h want 0",
                en_bits(), o_w_reg_data[0], o_w_mem_addr[0]);
        end
        i_rst_n = 1'b1;
        tick();
        checks++;
        if (o_alloc_idx[0] !== 4'd0 || o_alloc_idx[1] !== 4'd1) begin
            failures++; $display("FAIL reset_tags: got %0d/%0d want 0/1", o_alloc_idx[0], o_alloc_idx[1]);
        end
    endtask

    task automatic test_in_order_retire();
        alloc(0, 1'b1, 1'b0, 6'd5, 6'd1);
        alloc(1, 1'b1, 1'b0, 6'd6, 6'd2);
        tick(); idle();
        checks++;
        if (o_count !== 5'd2 || o_empty !== 1'b0) begin
            failures++; $display("FAIL alloc_count: got %0d empty %b want 2 empty 0", o_count, o_empty);
        end
        cmpl(0, 4'd1, 32'hB);
        tick(); idle();
        tick();
        checks++;
        if (en_bits() !== 6'b0) begin
            failures++; $display("FAIL young_done_blocked: enables %b want 000000", en_bits());
        end
        cmpl(0, 4'd0, 32'hA);
        tick(); idle();
        checks++;
        if (en_bits() !== 6'b0) begin
            failures++; $display("FAIL no_bypass: enables %b want 000000", en_bits());
        end
        tick();
        checks++;
        if (en_bits() !== 6'b110011) begin
            failures++; $display("FAIL dual_retire_en: got %b want 110011", en_bits());
        end
        checks++;
        if (o_w_reg_addr[0] !== 6'd5 || o_w_reg_data[0] !== 32'hA ||
            o_w_reg_addr[1] !== 6'd6 || o_w_reg_data[1] !== 32'hB) begin
            failures++; $display("FAIL dual_retire_data: got r%0d=%h r%0d=%h want r5=a r6=b",
                o_w_reg_addr[0], o_w_reg_data[0], o_w_reg_addr[1], o_w_reg_data[1]);
        end
        checks++;
        if (o_free_preg[0] !== 6'd1 || o_free_preg[1] !== 6'd2 || o_count !== 5'd0) begin
            failures++; $display("FAIL dual_retire_free: got %0d/%0d count %0d want 1/2 count 0",
                o_free_preg[0], o_free_preg[1], o_count);
        end
        tick();
        checks++;
        if (en_bits() !== 6'b0) begin
            failures++; $display("FAIL pulse_width: enables %b want 000000", en_bits());
        end
    endtask

    task automatic test_store();
        checks++;
        if (o_alloc_idx[0] !== 4'd2) begin
            failures++; $display("FAIL store_tag: got %0d want 2", o_alloc_idx[0]);
        end
        alloc(0, 1'b0, 1'b1, 6'd9, 6'd0);
        tick(); idle();
        cmpl(2, 4'd2, 32'h100);
        tick(); idle();
        tick();
        checks++;
        if (en_bits() !== 6'b001000 || o_w_mem_addr[0] !== 32'h100 || o_st_preg[0] !== 6'd9) begin
            failures++; $display("FAIL store_commit: enables %b addr %h st_preg %0d want 001000 100 9",
                en_bits(), o_w_mem_addr[0], o_st_preg[0]);
        end
    endtask

    task automatic test_full();
        // head = tail = 3 here; eight double allocations fill tags 3..15,0..2
        for (int i = 0; i < 8; i++) begin
            alloc(0, 1'b1, 1'b0, 6'(2*i + 3), 6'd0);
            alloc(1, 1'b1, 1'b0, 6'(2*i + 4), 6'd0);
            tick();
            if (i == 6) begin
                checks++;
                if (o_count !== 5'd14 || o_alloc_ready !== 1'b1) begin
                    failures++; $display("FAIL count14_ready: got %0d ready %b want 14 1", o_count, o_alloc_ready);
                end
            end
        end
        checks++;
        if ({o_count, o_full, o_alloc_ready, o_empty} !== {5'd16, 3'b100}) begin
            failures++; $display("FAIL full_status: got %b want %b", {o_count, o_full, o_alloc_ready, o_empty}, {5'd16, 3'b100});
        end
        tick(); idle();
        checks++;
        if (o_count !== 5'd16 || o_alloc_idx[0] !== 4'd3) begin
            failures++; $display("FAIL full_drop: count %0d tail %0d want 16 3", o_count, o_alloc_idx[0]);
        end
        cmpl(0, 4'd3, 32'h33);
        tick(); idle();
        tick();
        checks++;
        if (o_w_reg_en[0] !== 1'b1 || o_w_reg_data[0] !== 32'h33 || o_w_reg_addr[0] !== 6'd3) begin
            failures++; $display("FAIL full_head_retire: en %b r%0d=%h want 1 r3=33",
                o_w_reg_en[0], o_w_reg_addr[0], o_w_reg_data[0]);
        end
        checks++;
        if ({o_count, o_full, o_alloc_ready} !== {5'd15, 2'b00}) begin
            failures++; $display("FAIL count15_ready: got %b want %b", {o_count, o_full, o_alloc_ready}, {5'd15, 2'b00});
        end
        i_flush = 1'b1;
        tick(); idle();
        checks++;
        if (o_count !== 5'd0 || o_empty !== 1'b1 || o_alloc_idx[0] !== 4'd0) begin
            failures++; $display("FAIL flush_clears_full: count %0d empty %b tail %0d want 0 1 0",
                o_count, o_empty, o_alloc_idx[0]);
        end
    endtask

    task automatic test_back_to_back();
        int exp_row = 0;
        for (int c = 0; c < 24; c++) begin
            idle();
            if (c < 20) begin
                checks++;
                if (o_alloc_idx[0] !== 4'((2*c) % 16) || o_alloc_idx[1] !== 4'((2*c + 1) % 16)) begin
                    failures++; $display("FAIL wrap_tag c%0d: got %0d/%0d want %0d/%0d", c,
                        o_alloc_idx[0], o_alloc_idx[1], (2*c) % 16, (2*c + 1) % 16);
                end
                alloc(0, 1'b1, 1'b0, 6'(2*c), 6'd0);
                alloc(1, 1'b1, 1'b0, 6'(2*c + 1), 6'd0);
            end
            if (c >= 1 && c <= 20) begin
                cmpl(0, 4'((2*(c-1)) % 16), 32'(2*(c-1)));
                cmpl(1, 4'((2*(c-1) + 1) % 16), 32'(2*(c-1) + 1));
            end
            tick();
            for (int s = 0; s < 2; s++) begin
                if (o_w_reg_en[s] === 1'b1) begin
                    checks++;
                    if (o_w_reg_data[s] !== 32'(exp_row) || o_w_reg_addr[s] !== 6'(exp_row)) begin
                        failures++; $display("FAIL wrap_order slot%0d: got r%0d=%0d want row %0d",
                            s, o_w_reg_addr[s], o_w_reg_data[s], exp_row);
                    end
                    exp_row++;
                end
            end
            checks++;
            if (o_count > 5'd16) begin
                failures++; $display("FAIL wrap_count c%0d: got %0d want <=16", c, o_count);
            end
        end
        idle();
        checks++;
        if (exp_row != 40 || o_count !== 5'd0) begin
            failures++; $display("FAIL wrap_total: retired %0d count %0d want 40 0", exp_row, o_count);
        end
    endtask

    task automatic test_multi_lane();
        i_flush = 1'b1;
        tick(); idle();
        alloc(0, 1'b1, 1'b0, 6'd30, 6'd0); alloc(1, 1'b1, 1'b0, 6'd31, 6'd0);
        tick();
        alloc(0, 1'b1, 1'b0, 6'd32, 6'd0); alloc(1, 1'b1, 1'b0, 6'd33, 6'd0);
        tick(); idle();
        cmpl(0, 4'd3, 32'h11); cmpl(1, 4'd0, 32'h50); cmpl(2, 4'd3, 32'h22);
        tick(); idle();
        cmpl(0, 4'd1, 32'h51); cmpl(1, 4'd2, 32'h52);
        tick(); idle();
        checks++;
        if (o_w_reg_en[0] !== 1'b1 || o_w_reg_data[0] !== 32'h50 || o_w_reg_en[1] !== 1'b0) begin
            failures++; $display("FAIL single_retire: en %b/%b data %h want 1/0 50",
                o_w_reg_en[0], o_w_reg_en[1], o_w_reg_data[0]);
        end
        tick();
        checks++;
        if (o_w_reg_data[0] !== 32'h51 || o_w_reg_data[1] !== 32'h52 || o_w_reg_en[1] !== 1'b1) begin
            failures++; $display("FAIL pair_retire: got %h/%h en1 %b want 51/52 1",
                o_w_reg_data[0], o_w_reg_data[1], o_w_reg_en[1]);
        end
        tick();
        checks++;
        if (o_w_reg_en[0] !== 1'b1 || o_w_reg_data[0] !== 32'h22 || o_w_reg_addr[0] !== 6'd33) begin
            failures++; $display("FAIL lane_priority: en %b r%0d=%h want 1 r33=22",
                o_w_reg_en[0], o_w_reg_addr[0], o_w_reg_data[0]);
        end
        cmpl(0, 4'd7, 32'h77);
        tick(); idle();
        repeat (2) tick();
        checks++;
        if (en_bits() !== 6'b0 || o_count !== 5'd0 || o_empty !== 1'b1) begin
            failures++; $display("FAIL invalid_cmpl: enables %b count %0d want 000000 0", en_bits(), o_count);
        end
    endtask

    task automatic test_flush();
        i_flush = 1'b1;
        tick(); idle();
        alloc(0, 1'b1, 1'b0, 6'd10, 6'd1); alloc(1, 1'b1, 1'b0, 6'd11, 6'd2);
        tick();
        alloc(0, 1'b1, 1'b0, 6'd12, 6'd3); alloc(1, 1'b1, 1'b0, 6'd13, 6'd4);
        tick(); idle();
        alloc(0, 1'b1, 1'b0, 6'd14, 6'd5);
        cmpl(0, 4'd0, 32'hC0); cmpl(1, 4'd1, 32'hC1);
        tick(); idle();
        checks++;
        if (o_count !== 5'd5) begin
            failures++; $display("FAIL pre_flush_count: got %0d want 5", o_count);
        end
        i_flush = 1'b1;
        tick(); idle();
        checks++;
        if (en_bits() !== 6'b0 || o_count !== 5'd0 || o_empty !== 1'b1 || o_alloc_idx[0] !== 4'd0) begin
            failures++; $display("FAIL flush_state: enables %b count %0d empty %b tail %0d want 000000 0 1 0",
                en_bits(), o_count, o_empty, o_alloc_idx[0]);
        end
        tick();
        checks++;
        if (en_bits() !== 6'b0) begin
            failures++; $display("FAIL flush_discards_done: enables %b want 000000", en_bits());
        end
    endtask

    task automatic test_async_reset();
        alloc(0, 1'b1, 1'b0, 6'd20, 6'd7); alloc(1, 1'b1, 1'b0, 6'd21, 6'd8);
        tick(); idle();
        cmpl(0, 4'd0, 32'hD0); cmpl(1, 4'd1, 32'hD1);
        tick(); idle();
        tick();
        checks++;
        if (o_w_reg_en[0] !== 1'b1 || o_w_reg_data[0] !== 32'hD0) begin
            failures++; $display("FAIL pre_reset_retire: en %b data %h want 1 d0", o_w_reg_en[0], o_w_reg_data[0]);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (en_bits() !== 6'b0 || o_w_reg_data[0] !== 32'd0 || o_count !== 5'd0 || o_empty !== 1'b1) begin
            failures++; $display("FAIL async_reset: enables %b data %h count %0d want 000000 0 0",
                en_bits(), o_w_reg_data[0], o_count);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_in_order_retire();
        test_store();
        test_full();
        test_back_to_back();
        test_multi_lane();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Circular reorder buffer plus in-order retire stage: the reader end of the ROB rows that dispatch writes and complete marks done.
- Accepts up to 2 allocations per cycle from dispatch and up to 3 completions per cycle from the functional units.
- Retires up to 2 completed rows per cycle, strictly in program order.
- Retire drives register-file writes, memory store writes and physical-register frees back to rename.

Parameters:
- DEPTH, 16, number of ROB entries (power of two, ≥4)
- IDX_W, 4, log2(DEPTH)
- PREG_W, 6, physical register address width
- XLEN, 32, data word width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous clear of all entries
- i_alloc_valid[0:1]  in  1  allocation request per lane
- i_alloc_reg_write[0:1]  in  1  row writes a register
- i_alloc_mem_write[0:1]  in  1  row is a store
- i_alloc_pdst[0:1]  in  PREG_W  destination preg (store: source-data preg)
- i_alloc_old_pdst[0:1]  in  PREG_W  prior mapping of the architectural destination, freed on retire
- o_alloc_ready  out  1  at least 2 free entries
- o_alloc_idx[0:1]  out  IDX_W  tags assigned to lanes 0/1 (tail, tail+1)
- i_cmpl_valid[0:2]  in  1  completion per FU
- i_cmpl_idx[0:2]  in  IDX_W  ROB tag completed
- i_cmpl_data[0:2]  in  XLEN  result (store: effective address)
- o_w_reg_en[0:1]  out  1  register write
- o_w_reg_addr[0:1]  out  PREG_W
- o_w_reg_data[0:1]  out  XLEN
- o_w_mem_en[0:1]  out  1  store commit
- o_w_mem_addr[0:1]  out  XLEN
- o_st_preg[0:1]  out  PREG_W  preg holding store data
- o_free_en[0:1]  out  1  release old_pdst
- o_free_preg[0:1]  out  PREG_W
- o_count  out  IDX_W+1  occupied entries
- o_empty, o_full  out  1

Behaviour:
- Reset (async, i_rst_n=0):
  - head=tail=count=0; all entry valid/done bits cleared.
  - All write/free enables and addr/data outputs 0; o_empty=1, o_full=0, o_alloc_ready=1.
  - Reset mid-operation discards all in-flight rows.
- Allocation:
  - o_alloc_ready = (DEPTH−count ≥ 2), from registered count only; same-cycle retires are not credited.
  - o_alloc_idx[k] = tail+k mod DEPTH, combinational.
  - On the edge with ready=1, lane k with valid=1 is written valid=1, done=0; tail advances by the number accepted.
  - i_alloc_valid[1] without i_alloc_valid[0] is illegal; lane 1 is ignored.
  - ready=0: requests are dropped; dispatch must hold them.
- Completion:
  - Valid lane sets done=1 and data for entry idx at the edge.
  - Ignored if the entry is not valid.
  - Several lanes on the same idx: highest lane number wins.
  - Completion is visible to retire from the next cycle; no same-cycle bypass.
- Retire (evaluated on registered state; outputs registered):
  - Slot 0 retires head if valid&done.
  - Slot 1 retires head+1 only if slot 0 retires and head+1 is valid&done.
  - Per retired slot:
    - RegWrite=1 → w_reg_en=1, addr=pdst, data=data.
    - MemWrite=1 → w_mem_en=1, addr=data, st_preg=pdst; no reg write.
    - RegWrite=1 → free_en=1, free_preg=old_pdst.
    - Neither flag set → entry retires with no enables.
  - Retired entries are invalidated; head advances by 0/1/2 with wrap mod DEPTH.
  - Enables are 1-cycle pulses, 0 when no retire.
  - Latency: completion at edge N → write/free pulse high after edge N+1.
- count(next) = count + allocated − retired; o_full = (count==DEPTH); o_empty = (count==0). All registered.
- Simultaneous allocate and retire at full wrap: tail and head pointers are independent; allocation is still gated by registered count.
- i_flush=1 at an edge:
  - State returns to reset values.
  - Same-edge allocations, completions and retires are discarded.
  - Outputs are 0 after that edge.
  - Flush has priority over everything except reset.

Test Plan:
- Reset then 2 allocs (reg_write, pdst 5/6, old 1/2) with tags 0/1; complete idx1 data 0xB, then idx0 data 0xA → nothing retires before idx0 completes; next cycle both retire same cycle: reg 5←0xA, reg 6←0xB, free 1 and 2.
- Store alloc (mem_write, pdst 9) completed with address 0x100 → o_w_mem_en[0]=1, addr 0x100, st_preg 9, o_w_reg_en[0]=0, o_free_en[0]=0.
- Fill 16 entries without completion → o_full=1, o_alloc_ready=0 at count 15 and 16; further requests dropped, tail unchanged; complete head → count 15 next cycle after retire.
- Wrap: allocate/retire 40 rows 2 per cycle → tags wrap 15→0, retire order matches allocation order, count never exceeds 16.
- Lanes 0 and 2 both complete idx 3 with 0x11/0x22 → retired data 0x22; completion to an invalid idx 7 → ignored, no retire.
- Flush with 5 entries, 2 done → outputs 0 next cycle, count 0, o_empty=1; assert i_rst_n low mid-retire → outputs 0 immediately (asynchronously).
